// File: rtl/pipe_id.sv
// pipe_id: instruction-decode stage of a five-stage MIPS-style pipeline.
// Decodes newInst into ALU/memory/write-back controls and reads the two
// source operands from a 32 x 32-bit register file written by write-back.
//
// Ports:
//   clk        - clock; register-file writes on the rising edge
//   clrn       - asynchronous reset, active-high (clears the register file)
//   newInst    - instruction to decode
//   WBwreg     - write-back enable
//   WBwn       - write-back destination register
//   WBdata     - write-back data
//   IDwreg     - instruction writes a register
//   IDm2reg    - register result comes from memory (load)
//   IDwmem     - instruction writes memory (store)
//   IDaluc     - ALU operation code
//   IDshift    - ALU A operand is the shift amount
//   IDaluimm   - ALU B operand is the extended immediate
//   IDwn       - destination register number
//   IDqa/IDqb  - register-file values of rs / rt
//   IDimmeOrSa - extended immediate or zero-extended shift amount
//
// Optional build macro: PIPE_ID_WB_BYPASS_EN
//   defined   - a write-back to rs/rt is forwarded to IDqa/IDqb in the same cycle
//   undefined - reads return stored contents only
//
// All decode outputs are combinational (zero-cycle decode latency).

module pipe_id (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] newInst,
    input  logic        WBwreg,
    input  logic [4:0]  WBwn,
    input  logic [31:0] WBdata,
    output logic        IDwreg,
    output logic        IDm2reg,
    output logic        IDwmem,
    output logic [3:0]  IDaluc,
    output logic        IDshift,
    output logic        IDaluimm,
    output logic [4:0]  IDwn,
    output logic [31:0] IDqa,
    output logic [31:0] IDqb,
    output logic [31:0] IDimmeOrSa
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned IMM_W    = 16;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;

    // Instruction fields
    logic [5:0]        op;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] sa;
    logic [5:0]        func;
    logic [IMM_W-1:0]  imm;

    assign op   = newInst[31:26];
    assign rs   = newInst[25:21];
    assign rt   = newInst[20:16];
    assign rd   = newInst[15:11];
    assign sa   = newInst[10:6];
    assign func = newInst[5:0];
    assign imm  = newInst[15:0];

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Register file; r0 is never written so it stays zero after reset
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (WBwreg && (WBwn != '0)) begin
            regs[WBwn] <= WBdata;
        end
    end

`ifdef PIPE_ID_WB_BYPASS_EN
    // Write-through: a pending write-back to rs/rt is visible before the edge
    logic wb_live;
    assign wb_live = WBwreg && (WBwn != '0) && !clrn;

    always_comb begin
        IDqa = (rs == '0) ? '0 : regs[rs];
        IDqb = (rt == '0) ? '0 : regs[rt];
        if (wb_live && (WBwn == rs)) IDqa = WBdata;
        if (wb_live && (WBwn == rt)) IDqb = WBdata;
    end
`else
    // Stored contents only; a write-back shows up after its clock edge
    always_comb begin
        IDqa = (rs == '0) ? '0 : regs[rs];
        IDqb = (rt == '0) ? '0 : regs[rt];
    end
`endif

    // Control decode; defaults describe an undefined instruction
    always_comb begin
        IDwreg     = 1'b0;
        IDm2reg    = 1'b0;
        IDwmem     = 1'b0;
        IDaluc     = 4'b0000;
        IDshift    = 1'b0;
        IDaluimm   = 1'b0;
        IDwn       = rd;
        IDimmeOrSa = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

        unique case (op)
            OP_RTYPE: begin
                IDwreg = 1'b1;
                unique case (func)
                    FN_ADD:  IDaluc = 4'b0000;
                    FN_SUB:  IDaluc = 4'b0100;
                    FN_AND:  IDaluc = 4'b0001;
                    FN_OR:   IDaluc = 4'b0101;
                    FN_XOR:  IDaluc = 4'b0010;
                    FN_SLL:  IDaluc = 4'b0011;
                    FN_SRL:  IDaluc = 4'b0111;
                    FN_SRA:  IDaluc = 4'b1111;
                    default: IDwreg = 1'b0;
                endcase
                if (func == FN_SLL || func == FN_SRL || func == FN_SRA) begin
                    IDshift    = 1'b1;
                    IDimmeOrSa = {(DATA_W-REG_AW)'(0), sa};
                end
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                IDwreg   = 1'b1;
                IDaluimm = 1'b1;
                IDwn     = rt;
                unique case (op)
                    OP_ANDI: IDaluc = 4'b0001;
                    OP_ORI:  IDaluc = 4'b0101;
                    OP_XORI: IDaluc = 4'b0010;
                    OP_LUI:  IDaluc = 4'b0110;
                    default: IDaluc = 4'b0000;
                endcase
                // Only addi sign-extends; logical ops and lui zero-extend
                if (op != OP_ADDI) begin
                    IDimmeOrSa = {(DATA_W-IMM_W)'(0), imm};
                end
            end
            OP_LW: begin
                IDwreg   = 1'b1;
                IDm2reg  = 1'b1;
                IDaluimm = 1'b1;
                IDwn     = rt;
            end
            OP_SW: begin
                IDwmem   = 1'b1;
                IDaluimm = 1'b1;
                IDwn     = rt;
            end
            OP_BEQ, OP_BNE: begin
                IDaluc = 4'b0100;
                IDwn   = rt;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pipe_id.sv
// tb_pipe_id: directed bench for pipe_id with hand-computed expected values.
module tb_pipe_id;

    logic        clk;
    logic        clrn;
    logic [31:0] newInst;
    logic        WBwreg;
    logic [4:0]  WBwn;
    logic [31:0] WBdata;
    logic        IDwreg;
    logic        IDm2reg;
    logic        IDwmem;
    logic [3:0]  IDaluc;
    logic        IDshift;
    logic        IDaluimm;
    logic [4:0]  IDwn;
    logic [31:0] IDqa;
    logic [31:0] IDqb;
    logic [31:0] IDimmeOrSa;

    int passed;
    int total;

    pipe_id dut (
        .clk        (clk),
        .clrn       (clrn),
        .newInst    (newInst),
        .WBwreg     (WBwreg),
        .WBwn       (WBwn),
        .WBdata     (WBdata),
        .IDwreg     (IDwreg),
        .IDm2reg    (IDm2reg),
        .IDwmem     (IDwmem),
        .IDaluc     (IDaluc),
        .IDshift    (IDshift),
        .IDaluimm   (IDaluimm),
        .IDwn       (IDwn),
        .IDqa       (IDqa),
        .IDqb       (IDqb),
        .IDimmeOrSa (IDimmeOrSa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the full control bundle of the current instruction
    task automatic chk_ctl(input string tag, input logic wreg, input logic m2reg,
                           input logic wmem, input logic [3:0] aluc, input logic shift,
                           input logic aluimm, input logic [4:0] wn, input logic [31:0] ios);
        chk({tag, ".wreg"},   32'(IDwreg),   32'(wreg));
        chk({tag, ".m2reg"},  32'(IDm2reg),  32'(m2reg));
        chk({tag, ".wmem"},   32'(IDwmem),   32'(wmem));
        chk({tag, ".aluc"},   32'(IDaluc),   32'(aluc));
        chk({tag, ".shift"},  32'(IDshift),  32'(shift));
        chk({tag, ".aluimm"}, 32'(IDaluimm), 32'(aluimm));
        chk({tag, ".wn"},     32'(IDwn),     32'(wn));
        chk({tag, ".ios"},    IDimmeOrSa,    ios);
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        clrn    = 1'b1;
        newInst = 32'h0;
        WBwreg  = 1'b0;
        WBwn    = 5'd0;
        WBdata  = 32'h0;
        tick();
        tick();
        clrn = 1'b0;
        #1;

        // Reset state, sll r0 decode
        chk("rst.qa", IDqa, 32'h0);
        chk("rst.qb", IDqb, 32'h0);
        chk_ctl("sll0", 1, 0, 0, 4'b0011, 1, 0, 5'd0, 32'h0);

        // bne rs=0 rt=0 imm=0x0C21
        newInst = 32'h14000C21; #1;
        chk_ctl("bne", 0, 0, 0, 4'b0100, 0, 0, 5'd0, 32'h00000C21);
        chk("bne.qa", IDqa, 32'h0);
        chk("bne.qb", IDqb, 32'h0);

        // Write r2 = 0xF, then addi r1, r2, 0
        WBwreg = 1'b1; WBwn = 5'd2; WBdata = 32'h0000000F;
        tick();
        WBwreg = 1'b0;
        newInst = 32'h20410000; #1;
        chk("addi.qa", IDqa, 32'h0000000F);
        chk_ctl("addi", 1, 0, 0, 4'b0000, 0, 1, 5'd1, 32'h0);

        // Extension boundaries
        newInst = 32'h2041FFFF; #1;
        chk_ctl("addi_neg", 1, 0, 0, 4'b0000, 0, 1, 5'd1, 32'hFFFFFFFF);
        newInst = 32'h3441FFFF; #1;
        chk_ctl("ori", 1, 0, 0, 4'b0101, 0, 1, 5'd1, 32'h0000FFFF);
        newInst = 32'h00002FC3; #1;  // sra rd=5 sa=31
        chk_ctl("sra", 1, 0, 0, 4'b1111, 1, 0, 5'd5, 32'h0000001F);

        // Write to r0 ignored
        WBwreg = 1'b1; WBwn = 5'd0; WBdata = 32'hDEADBEEF;
        tick();
        WBwreg = 1'b0;
        newInst = 32'h00000020; #1;  // add r0, r0, r0
        chk("r0.qa", IDqa, 32'h0);
        chk("r0.qb", IDqb, 32'h0);
        chk("add.aluc", 32'(IDaluc), 32'h0);

        // sub r3, r2, r2
        newInst = 32'h00421822; #1;
        chk("sub.qa", IDqa, 32'h0000000F);
        chk("sub.qb", IDqb, 32'h0000000F);
        chk_ctl("sub", 1, 0, 0, 4'b0100, 0, 0, 5'd3, 32'h00001822);

        // Memory and lui
        newInst = 32'h8C448000; #1;  // lw r4, -0x8000(r2)
        chk_ctl("lw", 1, 1, 0, 4'b0000, 0, 1, 5'd4, 32'hFFFF8000);
        chk("lw.qa", IDqa, 32'h0000000F);
        newInst = 32'hAC010004; #1;  // sw r1, 4(r0)
        chk_ctl("sw", 0, 0, 1, 4'b0000, 0, 1, 5'd1, 32'h00000004);
        newInst = 32'h3C078000; #1;  // lui r7, 0x8000
        chk_ctl("lui", 1, 0, 0, 4'b0110, 0, 1, 5'd7, 32'h00008000);

        // Undefined opcode and undefined function
        newInst = 32'hFC00C800; #1;
        chk_ctl("bad_op", 0, 0, 0, 4'b0000, 0, 0, 5'd25, 32'hFFFFC800);
        newInst = 32'h0000283F; #1;
        chk_ctl("bad_fn", 0, 0, 0, 4'b0000, 0, 0, 5'd5, 32'h0000283F);

        // Write-back to r3 read as rt before and after the edge
        WBwreg = 1'b1; WBwn = 5'd3; WBdata = 32'h12345678;
        newInst = 32'h00031020; #1;  // add r2, r0, r3
`ifdef PIPE_ID_WB_BYPASS_EN
        chk("byp.pre", IDqb, 32'h12345678);
`else
        chk("byp.pre", IDqb, 32'h0);
`endif
        tick();
        WBwreg = 1'b0; #1;
        chk("byp.post", IDqb, 32'h12345678);

        // Asynchronous reset pulse between edges clears r2 and r3
        #2 clrn = 1'b1;
        #1 clrn = 1'b0;
        newInst = 32'h00431020; #1;  // add r2, r2, r3
        chk("clr.r2", IDqa, 32'h0);
        chk("clr.r3", IDqb, 32'h0);

        // Writes suppressed while reset is held
        clrn = 1'b1;
        WBwreg = 1'b1; WBwn = 5'd4; WBdata = 32'hA5A5A5A5;
        tick();
        WBwreg = 1'b0;
        clrn = 1'b0;
        newInst = 32'h00800020; #1;  // add r0, r4, r0
        chk("rst_wr.r4", IDqa, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
